// File: rtl/pic_ram_loader_pkg.sv
// Shared types and defaults for the picture RAM loader.
package pic_ram_loader_pkg;

  localparam int unsigned PIC_W_DEF   = 100;
  localparam int unsigned PIC_H_DEF   = 80;
  localparam int unsigned ADDR_W_DEF  = 13;
  localparam int unsigned TIMEOUT_DEF = 400000;
  localparam logic [7:0]  SYNC0_DEF   = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF   = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // True when a w x h picture fits in a RAM of 2**aw entries.
  function automatic logic pic_fits(input int unsigned w, input int unsigned h,
                                    input int unsigned aw);
    return (64'(w) * 64'(h)) <= (64'(1) << aw);
  endfunction

endpackage

// File: rtl/pic_ram_loader_if.sv
// Byte stream input and picture RAM write port of the loader.
interface pic_ram_loader_if import pic_ram_loader_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  // Loader side.
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_cnt
  );

  // Source / RAM / status side.
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/pic_ram_loader_gap_timer.sv
// Counts idle cycles between accepted bytes; flags the last allowed idle cycle.
module gap_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc_c
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal count: this idle cycle is the TIMEOUT-th in a row.
  assign o_tc_c = (r_cnt == TC);

  // Idle-cycle counter, cleared by the loader, held at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/pic_ram_loader.sv
// Framed RGB332 byte stream to sequential picture RAM writes.
module pic_ram_loader import pic_ram_loader_pkg::*; #(
  parameter int unsigned PIC_W   = PIC_W_DEF,
  parameter int unsigned PIC_H   = PIC_H_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter logic [7:0]  SYNC0   = SYNC0_DEF,
  parameter logic [7:0]  SYNC1   = SYNC1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pic_ram_loader_if.master  bus
);
  localparam int unsigned NPIX = PIC_W * PIC_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  if (!pic_fits(PIC_W, PIC_H, ADDR_W)) begin : g_size_check
    $error("pic_ram_loader: PIC_W*PIC_H does not fit in 2**ADDR_W");
  end

  state_e            r_state, w_state_next;
  logic              w_xfer, w_last, w_tc, w_timer_clr, w_timer_en, w_in_frame;
  logic [ADDR_W-1:0] r_idx;
  logic              r_rx_ready, r_wr_en, r_busy, r_frame_done, r_frame_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data, r_frame_cnt;

  assign w_xfer      = bus.rx_valid && r_rx_ready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_in_frame  = (r_state == ST_SYNC) || (r_state == ST_LOAD);
  assign w_timer_clr = w_xfer || !w_in_frame;
  assign w_timer_en  = !w_timer_clr;

  gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_timer_clr),
    .i_en    (w_timer_en),
    .o_tc_c  (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Header hunt, pixel load and one-cycle DONE/ERR; a transfer beats a timeout.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer && (bus.rx_data == SYNC0)) w_state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (w_xfer) begin
          if (bus.rx_data == SYNC1)      w_state_next = ST_LOAD;
          else if (bus.rx_data == SYNC0) w_state_next = ST_SYNC;
          else                           w_state_next = ST_IDLE;
        end else if (w_tc) begin
          w_state_next = ST_ERR;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          if (w_last) w_state_next = ST_DONE;
        end else if (w_tc) begin
          w_state_next = ST_ERR;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: pixel index, write port, handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_rx_ready   <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_rx_ready   <= !((w_state_next == ST_DONE) || (w_state_next == ST_ERR));
      r_busy       <= (w_state_next == ST_LOAD);
      r_wr_en      <= w_xfer && (r_state == ST_LOAD);
      r_frame_done <= (r_state == ST_DONE);
      r_frame_err  <= (r_state == ST_ERR);
      if (r_state == ST_DONE) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (r_state != ST_LOAD) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_wr_addr <= r_idx;
        r_wr_data <= bus.rx_data;
        r_idx     <= w_last ? '0 : r_idx + ADDR_W'(1);
      end
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.frame_cnt  = r_frame_cnt;
endmodule
